// File: rtl/frv_core_fetch_buffer_n_pkg.sv
// frv_core_fetch_buffer_n_pkg: shared fetch-buffer constants and RVC length decode.
package frv_core_fetch_buffer_n_pkg;
    localparam int HW_W  = 16;
    localparam int ENT_W = HW_W + 1;
    function automatic int fetch_hw(input int fw);
        return fw / HW_W;
    endfunction
    function automatic logic is_rvc32(input logic [1:0] lo);
        return lo == 2'b11;
    endfunction
endpackage

// File: rtl/frv_core_hw_shifter.sv
// frv_core_hw_shifter: shifts the halfword queue down by n_eat, then ORs masked entries in at idx.
module frv_core_hw_shifter #(
    parameter int DEPTH = 8,
    parameter int HW    = 2,
    parameter int W     = 17,
    parameter int DW    = 4
) (
    input  logic [DEPTH-1:0][W-1:0] q,
    input  logic [1:0]              n_eat,
    input  logic [DW-1:0]           idx,
    input  logic [HW-1:0][W-1:0]    vec,
    input  logic [HW-1:0]           mask,
    output logic [DEPTH-1:0][W-1:0] d
);
    logic [DEPTH-1:0][W-1:0] ins;
    // Entries above the occupancy are always zero, so an OR is a clean insert.
    always_comb begin
        ins = '0;
        for (int j = 0; j < HW; j++) ins[j] = mask[j] ? vec[j] : '0;
        d = (q >> (32'(n_eat) * W)) | (ins << (32'(idx) * W));
    end
endmodule

// File: rtl/frv_core_fetch_buffer_n.sv
// frv_core_fetch_buffer_n: halfword queue turning fetch responses into 16/32-bit instructions.
module frv_core_fetch_buffer_n
    import frv_core_fetch_buffer_n_pkg::*;
#(
    parameter int FW    = 32,
    parameter int DEPTH = 8,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int SW   = $clog2(FW / 16)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          flush,
    input  logic          f_valid,
    input  logic [SW-1:0] f_start,
    input  logic          f_err,
    input  logic [FW-1:0] f_in,
    output logic          f_ready,
    output logic [DW-1:0] buf_depth,
    output logic [31:0]   buf_out,
    output logic          buf_16,
    output logic          buf_32,
    output logic          buf_out_2,
    output logic          buf_out_4,
    output logic          buf_err,
    output logic          buf_valid,
    input  logic          buf_ready
);
    localparam int FETCH_HW = fetch_hw(FW);
    logic [DEPTH-1:0][ENT_W-1:0] ent_q, ent_d, shift_d;
    logic [DW-1:0] depth_q, depth_d, n_in, idx;
    logic [1:0] n_eat;
    logic [DW:0] room;
    logic [FW-1:0] f_al;
    logic [FETCH_HW-1:0][ENT_W-1:0] vec;
    logic [FETCH_HW-1:0] mask;
    logic accept;
    always_comb begin
        buf_32 = depth_q != '0 && is_rvc32(ent_q[0][1:0]);
        buf_16 = depth_q != '0 && !buf_32;
        buf_out = {ent_q[1][HW_W-1:0], ent_q[0][HW_W-1:0]};
        buf_out_2 = buf_16;
        // A faulted lone low half goes out now; its upper half will never arrive.
        buf_out_4 = buf_32 && (depth_q >= DW'(2) || ent_q[0][HW_W]);
        buf_valid = buf_out_2 || buf_out_4;
        buf_err = ent_q[0][HW_W] | (buf_32 & ent_q[1][HW_W]);
        n_eat = !(buf_ready && buf_valid) ? 2'd0 : (buf_32 && depth_q >= DW'(2)) ? 2'd2 : 2'd1;
        room = (DW+1)'(DEPTH) - {1'b0, depth_q} + (DW+1)'(n_eat);
        f_ready = room >= (DW+1)'(FETCH_HW);
        accept = f_valid && f_ready;
        n_in = accept ? DW'(FETCH_HW) - DW'(f_start) : '0;
        idx = depth_q - DW'(n_eat);
        f_al = f_in >> (32'(f_start) * HW_W);
        for (int i = 0; i < FETCH_HW; i++) begin
            vec[i] = {f_err, f_al[i*HW_W +: HW_W]};
            mask[i] = accept && i < FETCH_HW - int'(f_start);
        end
        depth_d = flush ? '0 : depth_q - DW'(n_eat) + n_in;
    end
    frv_core_hw_shifter #(.DEPTH(DEPTH), .HW(FETCH_HW), .W(ENT_W), .DW(DW)) u_shift (
        .q(ent_q), .n_eat(n_eat), .idx(idx), .vec(vec), .mask(mask), .d(shift_d)
    );
    assign ent_d = flush ? '0 : shift_d;
    assign buf_depth = depth_q;
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            depth_q <= '0;
            ent_q <= '0;
        end else begin
            depth_q <= depth_d;
            ent_q <= ent_d;
        end
    end
endmodule

// File: tb/tb_frv_core_fetch_buffer_n.sv
// tb_frv_core_fetch_buffer_n: directed checks of the fetch buffer at FW=32 and FW=64.
module tb_frv_core_fetch_buffer_n;
    logic g_clk = 1'b0, g_resetn = 1'b0;
    int total = 0, bad = 0;
    always #5 g_clk = ~g_clk;

    logic flush = 0, fv = 0, fs = 0, fe = 0, brdy = 0;
    logic [31:0] fin = '0;
    logic fr, b16, b32, bo2, bo4, berr, bval;
    logic [3:0] dep;
    logic [31:0] bo;
    frv_core_fetch_buffer_n #(.FW(32), .DEPTH(8)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .f_valid(fv), .f_start(fs),
        .f_err(fe), .f_in(fin), .f_ready(fr), .buf_depth(dep), .buf_out(bo), .buf_16(b16),
        .buf_32(b32), .buf_out_2(bo2), .buf_out_4(bo4), .buf_err(berr), .buf_valid(bval),
        .buf_ready(brdy)
    );

    logic w_fv = 0, w_fe = 0;
    logic [1:0] w_fs = '0;
    logic [63:0] w_fin = '0;
    logic w_fr, w_b16, w_b32, w_bo2, w_bo4, w_berr, w_bval;
    logic [3:0] w_dep;
    logic [31:0] w_bo;
    frv_core_fetch_buffer_n #(.FW(64), .DEPTH(8)) dut64 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(1'b0), .f_valid(w_fv), .f_start(w_fs),
        .f_err(w_fe), .f_in(w_fin), .f_ready(w_fr), .buf_depth(w_dep), .buf_out(w_bo),
        .buf_16(w_b16), .buf_32(w_b32), .buf_out_2(w_bo2), .buf_out_4(w_bo4), .buf_err(w_berr),
        .buf_valid(w_bval), .buf_ready(1'b0)
    );

    always @(posedge g_clk) begin
        if (g_resetn && ((fv && !fr) || (w_fv && !w_fr))) begin
            bad++;
            $display("FAIL protocol f_valid while f_ready=0 at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (fr !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", fr); end
        tick();
        g_resetn = 1'b1;
        tick();
        total++; if (dep !== 4'd0 || bval !== 1'b0 || bo !== 32'h0 || berr !== 1'b0) begin bad++; $display("FAIL rst_idle dep=%0d val=%b out=%h err=%b want 0", dep, bval, bo, berr); end
        fv = 1; fin = 32'h4501_0513;
        tick();
        fv = 0;
        total++; if (dep !== 4'd2) begin bad++; $display("FAIL rst_fill dep=%0d want=2", dep); end
        g_resetn = 1'b0;
        #1;
        total++; if (dep !== 4'd0 || bval !== 1'b0 || fr !== 1'b1 || bo !== 32'h0) begin bad++; $display("FAIL rst_async dep=%0d val=%b rdy=%b out=%h want 0,0,1,0", dep, bval, fr, bo); end
        tick();
        g_resetn = 1'b1;
        tick();
    endtask

    task automatic test_mixed_stream();
        brdy = 1; fv = 1; fin = 32'h4501_0513;
        tick();
        fin = 32'h0001_4581;
        #1;
        total++; if (bo !== 32'h4501_0513 || b32 !== 1'b1 || bo4 !== 1'b1 || dep !== 4'd2 || fr !== 1'b1) begin bad++; $display("FAIL mix_word out=%h b32=%b bo4=%b dep=%0d rdy=%b want 45010513,1,1,2,1", bo, b32, bo4, dep, fr); end
        tick();
        fv = 0;
        #1;
        total++; if (bo[15:0] !== 16'h4581 || b16 !== 1'b1 || bo2 !== 1'b1 || dep !== 4'd2) begin bad++; $display("FAIL mix_hw1 out=%h b16=%b dep=%0d want 4581,1,2", bo[15:0], b16, dep); end
        tick();
        total++; if (bo !== 32'h0000_0001 || bo2 !== 1'b1 || dep !== 4'd1 || berr !== 1'b0) begin bad++; $display("FAIL mix_hw2 out=%h bo2=%b dep=%0d err=%b want 00000001,1,1,0", bo, bo2, dep, berr); end
        tick();
        total++; if (dep !== 4'd0 || bval !== 1'b0) begin bad++; $display("FAIL mix_empty dep=%0d val=%b want 0,0", dep, bval); end
        brdy = 0;
    endtask

    task automatic test_misaligned64();
        w_fv = 1; w_fs = 2'd3; w_fin = {16'h8082, 48'h1111_2222_3333};
        tick();
        w_fv = 0; w_fs = 2'd0;
        total++; if (w_dep !== 4'd1 || w_bo2 !== 1'b1 || w_bo4 !== 1'b0 || w_bo !== 32'h0000_8082 || w_fr !== 1'b1) begin bad++; $display("FAIL mis64 dep=%0d bo2=%b bo4=%b out=%h rdy=%b want 1,1,0,00008082,1", w_dep, w_bo2, w_bo4, w_bo, w_fr); end
    endtask

    task automatic test_split_fault();
        fv = 1; fs = 1; fe = 1; fin = 32'h0513_dead;
        tick();
        fv = 0; fs = 0; fe = 0;
        total++; if (dep !== 4'd1 || b32 !== 1'b1 || bo4 !== 1'b1 || berr !== 1'b1 || bval !== 1'b1 || bo !== 32'h0000_0513) begin bad++; $display("FAIL fault_head dep=%0d b32=%b bo4=%b err=%b out=%h want 1,1,1,1,00000513", dep, b32, bo4, berr, bo); end
        brdy = 1;
        tick();
        brdy = 0;
        total++; if (dep !== 4'd0 || bval !== 1'b0 || berr !== 1'b0) begin bad++; $display("FAIL fault_eat dep=%0d val=%b err=%b want 0,0,0", dep, bval, berr); end
    endtask

    task automatic test_full_concurrent();
        fv = 1; fin = 32'h4501_0513;
        for (int i = 0; i < 4; i++) tick();
        fv = 0;
        total++; if (dep !== 4'd8 || fr !== 1'b0) begin bad++; $display("FAIL full_stall dep=%0d rdy=%b want 8,0", dep, fr); end
        brdy = 1;
        #1;
        total++; if (fr !== 1'b1 || bo4 !== 1'b1) begin bad++; $display("FAIL full_ready rdy=%b bo4=%b want 1,1", fr, bo4); end
        fv = 1; fin = 32'h0001_4581;
        tick();
        fv = 0;
        total++; if (dep !== 4'd8) begin bad++; $display("FAIL full_keep dep=%0d want=8", dep); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (dep !== 4'd2 || bo !== 32'h0001_4581 || b16 !== 1'b1) begin bad++; $display("FAIL full_tail dep=%0d out=%h b16=%b want 2,00014581,1", dep, bo, b16); end
        tick();
        tick();
        brdy = 0;
        total++; if (dep !== 4'd0) begin bad++; $display("FAIL full_drain dep=%0d want=0", dep); end
    endtask

    task automatic test_flush_collision();
        fv = 1; fe = 1; fin = 32'h4501_0513;
        tick();
        total++; if (berr !== 1'b1 || dep !== 4'd2) begin bad++; $display("FAIL flush_pre err=%b dep=%0d want 1,2", berr, dep); end
        flush = 1; brdy = 1; fin = 32'h0001_4581;
        tick();
        flush = 0; fv = 0; fe = 0; brdy = 0;
        total++; if (dep !== 4'd0 || bval !== 1'b0 || berr !== 1'b0 || bo !== 32'h0) begin bad++; $display("FAIL flush_clear dep=%0d val=%b err=%b out=%h want 0,0,0,0", dep, bval, berr, bo); end
        fv = 1; fin = 32'h0001_4581;
        tick();
        fv = 0;
        total++; if (dep !== 4'd2 || berr !== 1'b0 || bo !== 32'h0001_4581) begin bad++; $display("FAIL flush_after dep=%0d err=%b out=%h want 2,0,00014581", dep, berr, bo); end
    endtask

    initial begin
        test_reset();
        test_mixed_stream();
        test_misaligned64();
        test_split_fault();
        test_full_concurrent();
        test_flush_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frv_core_fetch_buffer_n.md
Name: frv_core_fetch_buffer_n

Overview:
Parametrised halfword queue between the fetch memory interface and decode. It accepts FW-bit read responses, with an optional starting halfword offset for misaligned branch targets. It emits one 16-bit or 32-bit instruction per cycle and tracks a fault bit for each stored halfword. A faulting halfword reaches decode even when the rest of its instruction was never fetched.

Parameters:
FW, 32, fetch data width in bits; legal values 32 or 64.
DEPTH, 8, storage depth in halfwords; must be at least 2*(FW/16) and at most 16.
DW, $clog2(DEPTH+1), width of the depth counter (derived, not overridable).

Ports:
g_clk  input  1  global clock
g_resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all contents
f_valid  input  1  fetch response present
f_start  input  $clog2(FW/16)  index of first valid halfword in f_in
f_err  input  1  fetch response faulted
f_in  input  FW  fetch response data, halfword 0 in the LSBs
f_ready  output  1  buffer accepts a full FW response this cycle
buf_depth  output  DW  current occupancy in halfwords
buf_out  output  32  halfwords 1:0 of the queue head
buf_16  output  1  head is a 16-bit instruction (buf_out[1:0]!=2'b11)
buf_32  output  1  head is a 32-bit instruction
buf_out_2  output  1  a complete 16-bit instruction is available
buf_out_4  output  1  a complete or faulted 32-bit instruction is available
buf_err  output  1  emitted instruction carries a fault
buf_valid  output  1  buf_out_2 | buf_out_4
buf_ready  input  1  decode consumes the head instruction

Behaviour:
- Reset (g_resetn low, async): depth 0, data and error storage 0. All outputs read 0 except f_ready, which reads 1.
- flush: synchronous, highest priority. The next cycle has depth 0. Any fetch presented or consumed in the flush cycle is discarded.
- Accept count: n_in = FW/16 - f_start halfwords (halfwords f_start..FW/16-1 of f_in), counted only when f_valid.
- f_ready = (DEPTH - depth + n_eat) >= FW/16. This is worst case, independent of f_start.
  - f_valid while !f_ready is a protocol error: the bench asserts it never happens, and the RTL ignores the data.
- Head decode, with buf_16/buf_32 forced 0 when depth=0:
  - buf_out_2 = depth>=1 & buf_16.
  - buf_out_4 = buf_32 & (depth>=2 | (depth==1 & err[0])).
  - A faulted lone low halfword is emitted immediately; the fetcher does not wait for a halfword that will never arrive.
- buf_err: err[0] for a 16-bit instruction; err[0]|err[1] for a 32-bit instruction.
- Consumption: n_eat = 1 on buf_out_2 & buf_ready; 2 on buf_out_4 & buf_ready, except 1 in the depth==1 fault case.
  - buf_ready without buf_valid is a no-op.
- Next state:
  - Queue shifts down by n_eat.
  - New halfwords are written at index depth - n_eat.
  - Every inserted halfword gets the error bit f_err.
  - depth_next = depth - n_eat + n_in. It never exceeds DEPTH, which is guaranteed by f_ready.
- Simultaneous fill and drain in the same cycle is required. A full buffer with a 32-bit eat accepts FW=32 data that same cycle.
- Halfwords above depth are held at 0, which keeps OR-insert logic clean.
- Latency: data accepted in cycle N is visible on buf_out in cycle N+1. No combinational f_in-to-buf_out path.
- The f_ready to buf_ready combinational dependency is permitted; there is no path from buf_ready to buf_valid.

Decomposition:
- The shared package frv_common.vh gains:
  - the RVC opcode-length test (low two bits == 2'b11 means 32-bit), as a function;
  - the constant FETCH_HW = FW/16.
- One natural sub-module, frv_core_hw_shifter: a parametrised shift-down-then-insert array over {err,data[15:0]} entries.
  - Inputs: n_eat, insert index, insert vector, insert mask.
  - Instantiated once with entry width 17.

Test Plan:
1. Reset: FW=32, g_resetn low mid-traffic -> depth 0, buf_valid 0, f_ready 1 immediately, without waiting for a clock edge.
2. Mixed stream: f_in=32'h4501_0513 then 32'h0001_4581, buf_ready held 1 -> decode sees 32'h4501_0513 (32-bit), then 16'h4581, then 16'h0001. Depth is 2, 2, 1 across those cycles.
3. Misaligned target: FW=64, f_start=3, f_in[63:48]=16'h8082 -> depth 1, buf_out_2=1, buf_out[15:0]=16'h8082.
4. Fault on split instruction: low halfword 16'h0513 with f_err=1, nothing further -> buf_out_4=1, buf_err=1 at depth 1; consumption leaves depth 0.
5. Full and concurrent: DEPTH=8, FW=32, buffer full, 32-bit head with buf_ready=1 -> f_ready=1; new word accepted; depth stays 8.
6. Flush collision: flush=1 with f_valid=1 and buf_ready=1 -> depth 0 next cycle, buf_valid 0, no error bits retained.
